// File: rtl/ysyx_23060191_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_23060191_ifu -- instruction fetch unit
//
// Fetches one instruction at a time from instruction memory. At most one
// request is outstanding. The fetched word is held for decode until it is
// consumed. A redirect (jump/branch) moves the PC and discards any fetch
// that is in flight or held.
//
// Parameters
//   CPU_WIDTH  address / instruction width
//   RESET_PC   first fetch address after reset
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_addr/req_ready fetch request to instruction memory
//   rsp_valid/rsp_data           one response pulse per accepted request
//   inst_valid/inst/inst_pc      held instruction towards decode
//   inst_ready                   decode consumes the held instruction
//   redirect_valid/redirect_pc   PC change request
//   fetch_err                    misaligned redirect seen (optional)
//
// Build option
//   YSYX_23060191_IFU_ALIGN_CHECK_EN: a redirect to a non word-aligned
//   target locks the unit in an error state (fetch_err=1) until reset.
//   When undefined, fetch_err is absent and the two low target bits are
//   forced to zero.
// ---------------------------------------------------------------------------
module ysyx_23060191_ifu #(
  parameter int                   CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(32'h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 req_valid,
  output logic [CPU_WIDTH-1:0] req_addr,
  input  logic                 req_ready,
  input  logic                 rsp_valid,
  input  logic [CPU_WIDTH-1:0] rsp_data,
  output logic                 inst_valid,
  output logic [CPU_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0] inst_pc,
  input  logic                 inst_ready,
  input  logic                 redirect_valid,
`ifdef YSYX_23060191_IFU_ALIGN_CHECK_EN
  output logic                 fetch_err,
`endif
  input  logic [CPU_WIDTH-1:0] redirect_pc
);

  typedef enum logic [2:0] {
    ST_REQ  = 3'd0,  // issue request for pc
    ST_WAIT = 3'd1,  // request accepted, waiting for the response
    ST_DROP = 3'd2,  // redirected while waiting: swallow the stale response
    ST_HOLD = 3'd3,  // instruction held for decode
    ST_ERR  = 3'd4   // misaligned redirect, locked until reset
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [CPU_WIDTH-1:0] pc_r;
  logic [CPU_WIDTH-1:0] pc_nxt_s;
  logic [CPU_WIDTH-1:0] inst_r;
  logic [CPU_WIDTH-1:0] inst_pc_r;
  logic [CPU_WIDTH-1:0] redirect_tgt_s;
  logic                 capture_s;
  logic                 req_valid_s;
  logic                 inst_valid_s;
  logic                 misalign_s;

  // Word-aligned redirect target; low two bits cleared.
  assign redirect_tgt_s = redirect_pc & {{(CPU_WIDTH-2){1'b1}}, 2'b00};

`ifdef YSYX_23060191_IFU_ALIGN_CHECK_EN
  assign misalign_s = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign fetch_err  = (state_r == ST_ERR);
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state, next-pc and handshake decode; redirect wins over everything.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    capture_s    = 1'b0;
    req_valid_s  = 1'b0;
    inst_valid_s = 1'b0;
    if (misalign_s && (state_r != ST_ERR)) begin
      state_nxt_s = ST_ERR;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (redirect_valid) begin
            pc_nxt_s = redirect_tgt_s;
          end else begin
            req_valid_s = 1'b1;
            if (req_ready) begin
              state_nxt_s = ST_WAIT;
            end else begin
              state_nxt_s = ST_REQ;
            end
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            pc_nxt_s = redirect_tgt_s;
            // A response in the same cycle closes the transaction at once.
            state_nxt_s = rsp_valid ? ST_REQ : ST_DROP;
          end else if (rsp_valid) begin
            capture_s   = 1'b1;
            state_nxt_s = ST_HOLD;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_DROP: begin
          if (redirect_valid) begin
            pc_nxt_s = redirect_tgt_s;
          end else begin
            pc_nxt_s = pc_r;
          end
          if (rsp_valid) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_DROP;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            // inst_valid is withheld so decode cannot take the dead word.
            pc_nxt_s    = redirect_tgt_s;
            state_nxt_s = ST_REQ;
          end else begin
            inst_valid_s = 1'b1;
            if (inst_ready) begin
              pc_nxt_s    = pc_r + CPU_WIDTH'(4);
              state_nxt_s = ST_REQ;
            end else begin
              state_nxt_s = ST_HOLD;
            end
          end
        end
        ST_ERR: begin
          state_nxt_s = ST_ERR;
        end
        default: begin
          state_nxt_s = ST_REQ;
        end
      endcase
    end
  end

  // Handshake strobes are suppressed while reset is asserted.
  always_comb begin
    if (rst) begin
      req_valid  = 1'b0;
      inst_valid = 1'b0;
    end else begin
      req_valid  = req_valid_s;
      inst_valid = inst_valid_s;
    end
  end

  assign req_addr = pc_r;
  assign inst     = inst_r;
  assign inst_pc  = inst_pc_r;

  // State, pc and held-instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_REQ;
      pc_r      <= RESET_PC;
      inst_r    <= '0;
      inst_pc_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (capture_s) begin
        inst_r    <= rsp_data;
        inst_pc_r <= pc_r;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
module tb_ysyx_23060191_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid, inst_valid, inst_ready, redirect_valid;
  logic [31:0] req_addr, rsp_data, inst, inst_pc, redirect_pc;
`ifdef YSYX_23060191_IFU_ALIGN_CHECK_EN
  logic        fetch_err;
`endif

  always #5 clk = ~clk;

  ysyx_23060191_ifu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid),
`ifdef YSYX_23060191_IFU_ALIGN_CHECK_EN
    .fetch_err(fetch_err),
`endif
    .redirect_pc(redirect_pc)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level reference: what the fetch unit owns, not how it is encoded.
  logic [31:0] m_pc = RST_PC, m_inst = 32'h0, m_ipc = 32'h0;
  bit m_busy = 1'b0;   // a request is in flight
  bit m_stale = 1'b0;  // the in-flight response must be thrown away
  bit m_have = 1'b0;   // an instruction is waiting for decode
  bit m_err = 1'b0;
  bit m_init = 1'b0;

  // Memory-side driver for the random phase.
  bit d_pend = 1'b0;
  int d_delay = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare, then advance the model.
  task automatic cyc(input bit r, input bit rr, input bit rv, input logic [31:0] rd,
                     input bit ir, input bit dv, input logic [31:0] dpc, output bit hs);
    bit e_req, e_ins, mis;
    @(negedge clk);
    rst = r; req_ready = rr; rsp_valid = rv; rsp_data = rd;
    inst_ready = ir; redirect_valid = dv; redirect_pc = dpc;
    #1;
    e_req = !r && !m_err && !m_busy && !m_have && !dv;
    e_ins = !r && !m_err && m_have && !dv;
    check("req_valid", 32'(req_valid), 32'(e_req));
    if (e_req) check("req_addr", req_addr, m_pc);
    check("inst_valid", 32'(inst_valid), 32'(e_ins));
    if (e_ins) begin
      check("inst", inst, m_inst);
      check("inst_pc", inst_pc, m_ipc);
    end
`ifdef YSYX_23060191_IFU_ALIGN_CHECK_EN
    if (m_init) check("fetch_err", 32'(fetch_err), 32'(m_err));
`endif
    hs = e_req && rr;
    mis = 1'b0;
`ifdef YSYX_23060191_IFU_ALIGN_CHECK_EN
    mis = (dpc[1:0] != 2'b00);
`endif
    if (r) begin
      m_pc = RST_PC; m_inst = 32'h0; m_ipc = 32'h0;
      m_busy = 1'b0; m_stale = 1'b0; m_have = 1'b0; m_err = 1'b0; m_init = 1'b1;
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (dv) begin
      if (mis) begin
        m_err = 1'b1;
      end else begin
        m_pc = {dpc[31:2], 2'b00};
        m_have = 1'b0;
        if (m_busy && rv) begin
          m_busy = 1'b0; m_stale = 1'b0;
        end else if (m_busy) begin
          m_stale = 1'b1;
        end
      end
    end else if (m_busy && rv) begin
      if (!m_stale) begin
        m_have = 1'b1; m_inst = rd; m_ipc = m_pc;
      end
      m_busy = 1'b0; m_stale = 1'b0;
    end else if (hs) begin
      m_busy = 1'b1;
    end else if (m_have && ir) begin
      m_have = 1'b0;
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    bit hs;
    bit r, rr, rv, ir, dv;
    logic [31:0] rd, dpc;
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset, then the basic fetch with everything immediate.
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, hs);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("first_addr", req_addr, 32'h8000_0000);
    cyc(1'b0, 1'b0, 1'b1, 32'h0010_0913, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, hs);
    check("lat_inst_valid", 32'(inst_valid), 32'd1);
    check("basic_inst", inst, 32'h0010_0913);
    check("basic_inst_pc", inst_pc, 32'h8000_0000);

    // Stalls on every handshake.
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    check("next_addr", req_addr, 32'h8000_0004);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0113, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, hs);
    check("stall_inst_pc", inst_pc, 32'h8000_0004);

    // Redirect while waiting; stale response must be dropped.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    check("addr_after_consume", req_addr, 32'h8000_0008);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0100, hs);
    cyc(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, hs);
    check("drop_no_inst", 32'(inst_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, hs);
    check("redir_wait_addr", req_addr, 32'h8000_0100);

    // Redirect in hold with inst_ready high.
    cyc(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0200, hs);
    check("redir_hold_iv", 32'(inst_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    check("redir_hold_addr", req_addr, 32'h8000_0200);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, hs);
    check("redir_req_no_hs", 32'(req_valid), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    check("top_addr", req_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0073, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    check("wrap_addr", req_addr, 32'h0000_0000);

`ifdef YSYX_23060191_IFU_ALIGN_CHECK_EN
    // Misaligned redirect locks up until reset.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0002, hs);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, hs);
    check("err_flag", 32'(fetch_err), 32'd1);
    check("err_no_req", 32'(req_valid), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    check("err_cleared", 32'(fetch_err), 32'd0);
    check("err_rst_addr", req_addr, 32'h8000_0000);
`else
    // Low target bits are ignored.
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0102, hs);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, hs);
    check("forced_align", req_addr, 32'h8000_0100);
`endif

    // Randomised traffic against the model, including mid-flight resets.
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 79) == 0);
      rr = ($urandom_range(0, 2) != 0);
      ir = ($urandom_range(0, 2) != 0);
      dv = ($urandom_range(0, 11) == 0);
      rd = $urandom;
      dpc = $urandom;
`ifdef YSYX_23060191_IFU_ALIGN_CHECK_EN
      if ($urandom_range(0, 7) != 0) dpc[1:0] = 2'b00;
`endif
      if (d_pend && d_delay == 0) begin
        rv = 1'b1;
        d_pend = 1'b0;
      end else begin
        if (d_pend) d_delay--;
        rv = !m_busy && !d_pend && ($urandom_range(0, 9) == 0);
      end
      cyc(r, rr, rv, rd, ir, dv, dpc, hs);
      if (hs) begin
        d_pend = 1'b1;
        d_delay = $urandom_range(0, 3);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
